// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI read arbiter.
package qspi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StGap
  } state_e;

  localparam logic [7:0]  CMD_FAST_READ_QUAD = 8'h6B;
  localparam int unsigned CMD_SCK            = 8;
  localparam int unsigned ADDR_SCK           = 24;
  localparam logic [3:0]  OE_SERIAL          = 4'b1101;
  localparam logic [3:0]  OE_IN              = 4'b0000;

endpackage

// File: rtl/qspi_read_arbiter_if.sv
// Requester-side bus of the quad-SPI read arbiter: two read request ports and the byte stream.
interface qspi_read_arbiter_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 4
) ();

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [LEN_W-1:0]  len0;
  logic              ack0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [LEN_W-1:0]  len1;
  logic              ack1;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              rd_id;
  logic              rd_last;
  logic              busy;

  modport master (
    output req0, addr0, len0, req1, addr1, len1,
    input  ack0, ack1, rd_valid, rd_data, rd_id, rd_last, busy
  );

  modport slave (
    input  req0, addr0, len0, req1, addr1, len1,
    output ack0, ack1, rd_valid, rd_data, rd_id, rd_last, busy
  );

endinterface

// File: rtl/qspi_shifter.sv
// SCK phase generator plus 32-bit shift register: serial-out on IO0, nibble-in from IO3..IO0.
module qspi_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        quad,
  input  logic [3:0]  nib_in,
  output logic        sck,
  output logic        tick,
  output logic        ser_out,
  output logic [3:0]  nib_last
);

  logic        ph_q;
  logic [31:0] sr_q;

  // tick marks the clk edge that ends the high phase: sample and shift happen there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q <= 1'b0;
      sr_q <= 32'h0;
    end else begin
      ph_q <= en & ~ph_q;
      if (load) begin
        sr_q <= load_word;
      end else if (en && ph_q) begin
        sr_q <= quad ? {sr_q[27:0], nib_in} : {sr_q[30:0], 1'b0};
      end
    end
  end

  assign sck      = ph_q;
  assign tick     = en & ph_q;
  assign ser_out  = sr_q[31];
  assign nib_last = sr_q[3:0];

endmodule

// File: rtl/qspi_read_arbiter.sv
// Two-port quad-SPI Fast Read (0x6B) sequencer and arbiter.
// Define QSPI_FIXED_PRIO_EN to make port 0 always win simultaneous requests (no round-robin).
module qspi_read_arbiter
  import qspi_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned DUMMY_SCK = 8,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic               clk,
  input  logic               rst,
  qspi_read_arbiter_if.slave bus,
  output logic               cs_n,
  output logic               sck,
  output logic [3:0]         qspi_out,
  output logic [3:0]         qspi_oe,
  input  logic [3:0]         qspi_in
);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              id_q, id_d;
  logic              pend, gnt_id, load, byte_done, last;
  logic              active, serial, quad, tick, ser_out;
  logic [3:0]        nib_last;
  logic [ADDR_W-1:0] addr_sel;
  logic              rd_valid_q, rd_last_q, rd_id_q;
  logic [7:0]        rd_data_q;

`ifndef QSPI_FIXED_PRIO_EN
  logic ptr_q, ptr_d;
`endif

  assign pend = bus.req0 | bus.req1;

`ifdef QSPI_FIXED_PRIO_EN
  assign gnt_id = ~bus.req0;
`else
  assign gnt_id = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
`endif

  assign addr_sel = gnt_id ? bus.addr1 : bus.addr0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    id_d      = id_q;
    load      = 1'b0;
    byte_done = 1'b0;
    last      = 1'b0;
    bus.ack0  = 1'b0;
    bus.ack1  = 1'b0;
`ifndef QSPI_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pend) begin
          state_d  = StCmd;
          cnt_d    = 8'd0;
          load     = 1'b1;
          id_d     = gnt_id;
          len_d    = gnt_id ? bus.len1 : bus.len0;
          // rst gating keeps ack low while the FSM is held in reset.
          bus.ack0 = ~gnt_id & ~rst;
          bus.ack1 = gnt_id & ~rst;
`ifndef QSPI_FIXED_PRIO_EN
          ptr_d    = ~gnt_id;
`endif
        end
      end
      StCmd: begin
        if (tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(CMD_SCK - 1)) begin
            state_d = StAddr;
            cnt_d   = 8'd0;
          end
        end
      end
      StAddr: begin
        if (tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(ADDR_SCK - 1)) begin
            state_d = StDummy;
            cnt_d   = 8'd0;
          end
        end
      end
      StDummy: begin
        if (tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(DUMMY_SCK - 1)) begin
            state_d = StData;
            cnt_d   = 8'd0;
          end
        end
      end
      StData: begin
        // cnt counts nibbles; odd count completes a byte, cnt/2 is the byte index.
        if (tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q[0]) begin
            byte_done = 1'b1;
            if (cnt_q[LEN_W:1] == len_q) begin
              last    = 1'b1;
              state_d = StGap;
              cnt_d   = 8'd0;
            end
          end
        end
      end
      StGap: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(CS_GAP - 1)) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      len_q      <= '0;
      id_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_id_q    <= 1'b0;
      rd_data_q  <= 8'h00;
`ifndef QSPI_FIXED_PRIO_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      id_q       <= id_d;
      rd_valid_q <= byte_done;
      rd_last_q  <= last;
      if (byte_done) begin
        rd_data_q <= {nib_last, qspi_in};
        rd_id_q   <= id_q;
      end
`ifndef QSPI_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  always_comb begin
    active   = (state_q == StCmd) || (state_q == StAddr) ||
               (state_q == StDummy) || (state_q == StData);
    serial   = (state_q == StCmd) || (state_q == StAddr);
    quad     = (state_q == StDummy) || (state_q == StData);
    cs_n     = ~active;
    qspi_oe  = serial ? OE_SERIAL : OE_IN;
    // IO3/IO2 held high so HOLD# and WP# stay inactive during the serial phases.
    qspi_out = serial ? {2'b11, 1'b0, ser_out} : 4'b0000;
  end

  qspi_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .en       (active),
    .load     (load),
    .load_word({CMD_FAST_READ_QUAD, 24'(addr_sel)}),
    .quad     (quad),
    .nib_in   (qspi_in),
    .sck      (sck),
    .tick     (tick),
    .ser_out  (ser_out),
    .nib_last (nib_last)
  );

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_id    = rd_id_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_qspi_read_arbiter.sv
// Directed bench for qspi_read_arbiter with a behavioural quad-SPI flash model.
module tb_qspi_read_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n, sck;
  logic [3:0] qspi_out, qspi_oe;
  logic [3:0] qspi_in = 4'h0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  qspi_read_arbiter_if #(.ADDR_W(24), .LEN_W(4)) bus ();

  qspi_read_arbiter #(
    .ADDR_W(24), .LEN_W(4), .DUMMY_SCK(8), .CS_GAP(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cs_n    (cs_n),
    .sck     (sck),
    .qspi_out(qspi_out),
    .qspi_oe (qspi_oe),
    .qspi_in (qspi_in)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a == 24'h012345) return 8'hA5;
    return a[7:0] + 8'h3C;
  endfunction

  // Flash model: captures cmd+addr on IO0, drives data nibbles after 8 dummy clocks.
  int          sck_cnt = 0;
  int          bad_serial = 0;
  int          bad_in = 0;
  int          fl_n;
  logic [31:0] cmd_cap = 32'h0;
  logic [7:0]  fl_b;

  always @(posedge sck or posedge cs_n) begin
    if (cs_n) begin
      sck_cnt = 0;
    end else begin
      if (sck_cnt < 32) begin
        cmd_cap = {cmd_cap[30:0], qspi_out[0]};
        if (qspi_oe !== 4'b1101 || qspi_out[3:2] !== 2'b11) bad_serial++;
      end else begin
        if (qspi_oe !== 4'b0000) bad_in++;
        if (sck_cnt >= 40) begin
          fl_n = sck_cnt - 40;
          fl_b = mem_byte(cmd_cap[23:0] + 24'(fl_n / 2));
          qspi_in = fl_n[0] ? fl_b[3:0] : fl_b[7:4];
        end
      end
      sck_cnt++;
    end
  end

  int ack0_cnt = 0;
  always @(negedge clk) begin
    #1;
    if (bus.ack0 === 1'b1) ack0_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Raises a request and waits for its ack; drops req on the following negedge.
  task automatic request(input bit port, input logic [23:0] a, input logic [3:0] l,
                         output bit got);
    @(negedge clk);
    if (port) begin bus.addr1 = a; bus.len1 = l; bus.req1 = 1'b1; end
    else      begin bus.addr0 = a; bus.len0 = l; bus.req0 = 1'b1; end
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      #1;
      if ((port ? bus.ack1 : bus.ack0) === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
    n_cmp++; if (sck !== 1'b0) begin n_bad++; $display("FAIL rst_sck: got %b want 0", sck); end
    n_cmp++; if (qspi_oe !== 4'h0) begin n_bad++; $display("FAIL rst_oe: got %h want 0", qspi_oe); end
    n_cmp++; if (qspi_out !== 4'h0) begin n_bad++; $display("FAIL rst_out: got %h want 0", qspi_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.ack0 !== 1'b0) begin n_bad++; $display("FAIL rst_ack0: got %b want 0", bus.ack0); end
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0) begin
      n_bad++; $display("FAIL rst_rd: got %b%b want 00", bus.rd_valid, bus.rd_last);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    bit got, found;
    int lat, a0;
    bad_serial = 0; bad_in = 0; a0 = ack0_cnt;
    request(1'b0, 24'h012345, 4'd0, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL single_ack: got 0 want 1"); end
    lat = 1; found = 1'b0;
    while (lat < 300 && !found) begin
      @(negedge clk); lat++;
      if (bus.rd_valid === 1'b1) found = 1'b1;
    end
    n_cmp++; if (lat != 85) begin n_bad++; $display("FAIL single_latency: got %0d want 85", lat); end
    n_cmp++; if (bus.rd_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", bus.rd_data); end
    n_cmp++; if (bus.rd_id !== 1'b0) begin n_bad++; $display("FAIL single_id: got %b want 0", bus.rd_id); end
    n_cmp++; if (bus.rd_last !== 1'b1) begin n_bad++; $display("FAIL single_last: got %b want 1", bus.rd_last); end
    repeat (10) @(negedge clk);
    n_cmp++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL single_cs_after: got %b want 1", cs_n); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b want 0", bus.busy); end
    n_cmp++; if (qspi_oe !== 4'h0) begin n_bad++; $display("FAIL idle_oe: got %h want 0", qspi_oe); end
    n_cmp++; if (cmd_cap !== 32'h6B012345) begin n_bad++; $display("FAIL single_cmd: got %h want 6b012345", cmd_cap); end
    n_cmp++; if (bad_serial != 0) begin n_bad++; $display("FAIL oe_serial: got %0d bad want 0", bad_serial); end
    n_cmp++; if (bad_in != 0) begin n_bad++; $display("FAIL oe_in: got %0d bad want 0", bad_in); end
    n_cmp++; if (ack0_cnt - a0 != 1) begin n_bad++; $display("FAIL single_ack_count: got %0d want 1", ack0_cnt - a0); end
  endtask

  task automatic test_burst;
    bit got;
    int k, prev;
    logic [7:0] exp_b;
    request(1'b1, 24'h000100, 4'd15, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL burst_ack: got 0 want 1"); end
    k = 0; prev = 0;
    for (int t = 2; t < 170; t++) begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) begin
        exp_b = mem_byte(24'h000100 + 24'(k));
        n_cmp++; if (bus.rd_data !== exp_b) begin n_bad++; $display("FAIL burst_data[%0d]: got %h want %h", k, bus.rd_data, exp_b); end
        n_cmp++; if (bus.rd_last !== (k == 15)) begin n_bad++; $display("FAIL burst_last[%0d]: got %b want %b", k, bus.rd_last, k == 15); end
        n_cmp++; if (bus.rd_id !== 1'b1) begin n_bad++; $display("FAIL burst_id[%0d]: got %b want 1", k, bus.rd_id); end
        if (k > 0) begin
          n_cmp++; if (t - prev != 4) begin n_bad++; $display("FAIL burst_spacing[%0d]: got %0d want 4", k, t - prev); end
        end
        prev = t; k++;
      end
    end
    n_cmp++; if (k != 16) begin n_bad++; $display("FAIL burst_count: got %0d want 16", k); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL burst_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_round_robin;
    int order[$];
    int exp_o[4] = '{0, 1, 0, 1};
    int round, both;
    bit drop0, drop1;
    @(negedge clk);
    bus.addr0 = 24'h000010; bus.len0 = 4'd0; bus.addr1 = 24'h000020; bus.len1 = 4'd0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    round = 1; both = 0; drop0 = 1'b0; drop1 = 1'b0;
    for (int i = 0; i < 1200 && order.size() < 4; i++) begin
      #1;
      if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both++;
      if (bus.ack0 === 1'b1) begin order.push_back(0); drop0 = 1'b1; end
      if (bus.ack1 === 1'b1) begin order.push_back(1); drop1 = 1'b1; end
      @(negedge clk);
      if (drop0) begin bus.req0 = 1'b0; drop0 = 1'b0; end
      if (drop1) begin bus.req1 = 1'b0; drop1 = 1'b0; end
      if (round == 1 && order.size() == 2 && bus.busy === 1'b0 && !bus.req0 && !bus.req1) begin
        bus.req0 = 1'b1; bus.req1 = 1'b1; round = 2;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    n_cmp++; if (order.size() != 4) begin n_bad++; $display("FAIL rr_grants: got %0d want 4", order.size()); end
    for (int k = 0; k < order.size() && k < 4; k++) begin
      n_cmp++; if (order[k] != exp_o[k]) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_o[k]); end
    end
    n_cmp++; if (both != 0) begin n_bad++; $display("FAIL rr_double_ack: got %0d want 0", both); end
    for (int i = 0; i < 500 && bus.busy !== 1'b0; i++) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rr_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    int order[$];
`ifdef QSPI_FIXED_PRIO_EN
    int exp_o[3] = '{0, 0, 0};
`else
    int exp_o[3] = '{0, 1, 0};
`endif
    int run, gap, both;
    bit seen_low;
    @(negedge clk);
    bus.addr0 = 24'h000040; bus.len0 = 4'd0; bus.addr1 = 24'h000050; bus.len1 = 4'd0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    run = 0; gap = -1; both = 0; seen_low = 1'b0;
    for (int i = 0; i < 1000 && order.size() < 3; i++) begin
      #1;
      if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both++;
      if (bus.ack0 === 1'b1) order.push_back(0);
      else if (bus.ack1 === 1'b1) order.push_back(1);
      if (cs_n === 1'b0) begin
        if (seen_low && run > 0 && gap < 0) gap = run;
        seen_low = 1'b1; run = 0;
      end else if (seen_low) begin
        run++;
      end
      @(negedge clk);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    n_cmp++; if (order.size() != 3) begin n_bad++; $display("FAIL b2b_grants: got %0d want 3", order.size()); end
    for (int k = 0; k < order.size() && k < 3; k++) begin
      n_cmp++; if (order[k] != exp_o[k]) begin n_bad++; $display("FAIL b2b_order[%0d]: got %0d want %0d", k, order[k], exp_o[k]); end
    end
    n_cmp++; if (gap != 3) begin n_bad++; $display("FAIL b2b_cs_gap: got %0d want 3", gap); end
    n_cmp++; if (both != 0) begin n_bad++; $display("FAIL b2b_double_ack: got %0d want 0", both); end
    for (int i = 0; i < 500 && bus.busy !== 1'b0; i++) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    bit got, found;
    int nb, seen, lat;
    request(1'b0, 24'h000200, 4'd7, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL mid_ack: got 0 want 1"); end
    nb = 0;
    for (int i = 0; i < 300 && nb < 2; i++) begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) nb++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL mid_cs_n: got %b want 1", cs_n); end
    n_cmp++; if (qspi_oe !== 4'h0) begin n_bad++; $display("FAIL mid_oe: got %h want 0", qspi_oe); end
    n_cmp++; if (sck !== 1'b0) begin n_bad++; $display("FAIL mid_sck: got %b want 0", sck); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rd_valid: got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rd_valid !== 1'b0 || cs_n !== 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL mid_held: got %0d active cycles want 0", seen); end
    rst = 1'b0;
    @(negedge clk);
    request(1'b1, 24'h000300, 4'd1, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL post_ack: got 0 want 1"); end
    lat = 1; found = 1'b0;
    while (lat < 300 && !found) begin
      @(negedge clk); lat++;
      if (bus.rd_valid === 1'b1) found = 1'b1;
    end
    n_cmp++; if (lat != 85) begin n_bad++; $display("FAIL post_latency: got %0d want 85", lat); end
    n_cmp++; if (bus.rd_data !== 8'h3C || bus.rd_last !== 1'b0) begin
      n_bad++; $display("FAIL post_byte0: got %h/%b want 3c/0", bus.rd_data, bus.rd_last);
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3D || bus.rd_last !== 1'b1) begin
      n_bad++; $display("FAIL post_byte1: got %b/%h/%b want 1/3d/1", bus.rd_valid, bus.rd_data, bus.rd_last);
    end
    n_cmp++; if (cmd_cap !== 32'h6B000300) begin n_bad++; $display("FAIL post_cmd: got %h want 6b000300", cmd_cap); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
